// File: rtl/ps2_rx_checked.sv
// ps2_rx_checked
// PS/2 device-to-host frame receiver with a ps2c glitch filter. It checks
// the start bit, odd parity and the stop bit, and has an optional watchdog
// that aborts frames that stall part-way through.
//
// Optional feature macro: PS2_RX_TIMEOUT_EN
//   defined   : the watchdog counter and the abort path are built.
//   undefined : there is no counter, timeout_tick is tied to 0, and a
//               stalled frame is recovered only by reset.
//
// Parameters:
//   FILTER_LEN      depth of the ps2c glitch filter in clk cycles (2..32)
//   TIMEOUT_CYCLES  inter-edge watchdog limit in clk cycles (>= 2)
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   ps2d          raw PS/2 data line
//   ps2c          raw PS/2 clock line
//   rx_en         permits acceptance of a new start bit
//   rx_busy       high whenever the FSM is not in IDLE
//   rx_done_tick  one-cycle pulse when a frame has completed
//   dout          received data byte (sent LSB first on the wire)
//   parity_err    pulse with rx_done_tick when odd parity failed
//   frame_err     pulse with rx_done_tick when the stop bit was 0
//   timeout_tick  one-cycle pulse when the watchdog aborts a frame

module ps2_rx_checked #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic       rx_busy,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick
);

  typedef enum logic [1:0] {
    IDLE,
    DPS,
    LOAD
  } state_t;

  state_t                  state_reg, state_next;
  logic [FILTER_LEN-1:0]   filt_reg;
  logic                    f_ps2c_reg, f_ps2c_next;
  logic                    fall_edge;
  logic [3:0]              n_reg, n_next;
  logic [10:0]             b_reg, b_next;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_reg, wd_next;
`else
  // The watchdog limit has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 1);
`endif

  // The start bit stays in the shift register but is never read again:
  // IDLE only accepts an edge when ps2d is already low.
  logic unused_start;
  assign unused_start = b_reg[0];

  // Glitch filter: ps2c shifts in at the MSB, and the filtered clock
  // changes only after FILTER_LEN identical samples in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_reg   <= '0;
      f_ps2c_reg <= 1'b0;
    end else begin
      filt_reg   <= {ps2c, filt_reg[FILTER_LEN-1:1]};
      f_ps2c_reg <= f_ps2c_next;
    end
  end

  // Filtered clock level. It holds its value while the window is mixed,
  // so short glitches never reach the edge detector.
  always_comb begin
    f_ps2c_next = f_ps2c_reg;
    if (&filt_reg)
      f_ps2c_next = 1'b1;
    else if (~|filt_reg)
      f_ps2c_next = 1'b0;
  end

  assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

  // State, bit counter, shift register and (optional) watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      b_reg     <= '0;
`ifdef PS2_RX_TIMEOUT_EN
      wd_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
`ifdef PS2_RX_TIMEOUT_EN
      wd_reg    <= wd_next;
`endif
    end
  end

  // Next-state logic. Bits are sampled from raw ps2d on each filtered
  // falling edge and shifted in from the top, so the start bit ends up in
  // b_reg[0] and the stop bit in b_reg[10]. In DPS a falling edge takes
  // priority over watchdog expiry in the same cycle.
  always_comb begin
    state_next   = state_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    rx_done_tick = 1'b0;
    timeout_tick = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
    wd_next      = wd_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (fall_edge && rx_en && !ps2d) begin
          b_next     = {ps2d, b_reg[10:1]};
          n_next     = 4'd9;
          state_next = DPS;
`ifdef PS2_RX_TIMEOUT_EN
          wd_next    = '0;
`endif
        end
      end
      DPS: begin
        if (fall_edge) begin
          b_next = {ps2d, b_reg[10:1]};
`ifdef PS2_RX_TIMEOUT_EN
          wd_next = '0;
`endif
          if (n_reg == 4'd0)
            state_next = LOAD;
          else
            n_next = n_reg - 4'd1;
        end
`ifdef PS2_RX_TIMEOUT_EN
        else if (wd_reg == WD_MAX) begin
          state_next   = IDLE;
          timeout_tick = 1'b1;
          wd_next      = '0;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
`endif
      end
      LOAD: begin
        rx_done_tick = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The error flags are qualified by the done pulse, so they are never
  // seen outside the LOAD cycle.
  assign rx_busy    = (state_reg != IDLE);
  assign dout       = b_reg[8:1];
  assign parity_err = rx_done_tick & ~(^b_reg[9:1]);
  assign frame_err  = rx_done_tick & ~b_reg[10];

endmodule

// File: tb/tb_ps2_rx_checked.sv
// tb_ps2_rx_checked
// Scoreboard testbench for ps2_rx_checked. Expected bytes and flags are
// pushed when a frame is driven and compared when rx_done_tick fires.
// The watchdog scenario adapts to whether PS2_RX_TIMEOUT_EN is defined.

module tb_ps2_rx_checked;

  localparam int FLEN    = 4;
  localparam int TOUT    = 1000;
  localparam int HALF_HI = 50;
  localparam int LOW_LEN = 100;

  logic       clk;
  logic       reset;
  logic       ps2d;
  logic       ps2c;
  logic       rx_en;
  logic       rx_busy;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_tick;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];

  int total_checks;
  int fail_count;
  int cycle;
  int done_count;
  int timeout_count;
  int timeout_cycle;
  int last_low_cycle;

  ps2_rx_checked #(
    .FILTER_LEN(FLEN),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2d(ps2d),
    .ps2c(ps2c),
    .rx_en(rx_en),
    .rx_busy(rx_busy),
    .rx_done_tick(rx_done_tick),
    .dout(dout),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .timeout_tick(timeout_tick)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count posedges so that event times can be compared in cycles.
  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling clock edge: pop and compare on each done pulse,
  // and record when watchdog pulses happen.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done_tick) begin
        done_count <= done_count + 1;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("dout", {24'd0, dout}, {24'd0, e.data});
          checkOutput("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          checkOutput("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
          checkOutput("busy_at_done", {31'd0, rx_busy}, 32'd1);
        end
      end
      if (timeout_tick) begin
        timeout_count <= timeout_count + 1;
        timeout_cycle <= cycle;
      end
    end
  end

  // Drive the first nbits of a frame (start, d0..d7, parity, stop) with a
  // 200-cycle bit period; optionally queue the expected result.
  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                               input int nbits, input bit push);
    logic [10:0] frame;
    exp_t e;
    frame = {stop, par, data, 1'b0};
    if (push) begin
      e.data = data;
      e.perr = ~(^{par, data});
      e.ferr = ~stop;
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      ps2d = frame[i];
      repeat (HALF_HI) @(negedge clk);
      ps2c = 1'b0;
      last_low_cycle = cycle;
      repeat (LOW_LEN) @(negedge clk);
      ps2c = 1'b1;
      repeat (HALF_HI) @(negedge clk);
    end
    ps2d = 1'b1;
  endtask

  // One isolated ps2c low pulse with the given data level.
  task automatic pulseClock(input logic d, input string tag);
    ps2d = d;
    repeat (HALF_HI) @(negedge clk);
    ps2c = 1'b0;
    repeat (LOW_LEN) @(negedge clk);
    checkOutput({tag, "_busy_low"}, {31'd0, rx_busy}, 32'd0);
    ps2c = 1'b1;
    repeat (HALF_HI) @(negedge clk);
    checkOutput({tag, "_busy_after"}, {31'd0, rx_busy}, 32'd0);
    ps2d = 1'b1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_dout"}, {24'd0, dout}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, rx_done_tick}, 32'd0);
    checkOutput({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    checkOutput({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    checkOutput({tag, "_tout"}, {31'd0, timeout_tick}, 32'd0);
  endtask

  // Main sequence.
  initial begin
    int base_done;
    int base_tout;
    total_checks  = 0;
    fail_count    = 0;
    cycle         = 0;
    done_count    = 0;
    timeout_count = 0;
    timeout_cycle = 0;
    last_low_cycle = 0;
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("in_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkIdleOutputs("post_reset");
    rx_en = 1'b1;

    // Good frame.
    $display("[TB] good frame");
    base_done = done_count;
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("t1_done_count", done_count - base_done, 32'd1);
    checkOutput("t1_busy_after", {31'd0, rx_busy}, 32'd0);

    // Parity error.
    $display("[TB] parity error");
    applyStimulus(8'h1C, 1'b1, 1'b1, 11, 1'b1);
    repeat (20) @(negedge clk);

    // Stop-bit error.
    $display("[TB] stop-bit error");
    applyStimulus(8'hF0, 1'b1, 1'b0, 11, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("t3_dout_hold", {24'd0, dout}, 32'hF0);

    // Start-bit rejection.
    $display("[TB] start-bit rejection");
    base_done = done_count;
    base_tout = timeout_count;
    rx_en = 1'b1;
    pulseClock(1'b1, "rej_high");
    rx_en = 1'b0;
    pulseClock(1'b0, "rej_dis");
    rx_en = 1'b1;
    repeat (TOUT + 50) @(negedge clk);
    checkOutput("rej_done", done_count - base_done, 32'd0);
    checkOutput("rej_tout", timeout_count - base_tout, 32'd0);

    // Timeout and recovery.
    $display("[TB] timeout and recovery");
    base_done = done_count;
    base_tout = timeout_count;
    applyStimulus(8'h5A, 1'b1, 1'b1, 5, 1'b0);
    repeat (TOUT + 100) @(negedge clk);
    checkOutput("t5_done", done_count - base_done, 32'd0);
`ifdef PS2_RX_TIMEOUT_EN
    checkOutput("t5_tout_count", timeout_count - base_tout, 32'd1);
    checkOutput("t5_tout_cycle", timeout_cycle, last_low_cycle + FLEN + TOUT);
    checkOutput("t5_busy", {31'd0, rx_busy}, 32'd0);
`else
    checkOutput("t5_tout_count", timeout_count - base_tout, 32'd0);
    checkOutput("t5_stalled", {31'd0, rx_busy}, 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t5_busy", {31'd0, rx_busy}, 32'd0);
`endif
    applyStimulus(8'hAA, 1'b1, 1'b1, 11, 1'b1);
    repeat (20) @(negedge clk);

    // Reset mid-frame, then glitch immunity.
    $display("[TB] reset and glitches");
    base_done = done_count;
    base_tout = timeout_count;
    applyStimulus(8'h3C, 1'b1, 1'b1, 6, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkIdleOutputs("t6_reset");
    for (int g = 0; g < 4; g++) begin
      ps2c = 1'b0;
      repeat (2) @(negedge clk);
      ps2c = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("t6_glitch_busy", {31'd0, rx_busy}, 32'd0);
    end
    repeat (TOUT + 50) @(negedge clk);
    checkOutput("t6_done", done_count - base_done, 32'd0);
    checkOutput("t6_tout", timeout_count - base_tout, 32'd0);
    applyStimulus(8'h55, 1'b1, 1'b1, 11, 1'b1);
    repeat (20) @(negedge clk);

    checkOutput("queue_empty", exp_q.size(), 32'd0);
    checkOutput("total_done", done_count, 32'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

endmodule

// File: doc/ps2_rx_checked.md
# ps2_rx_checked

Parametrised PS/2 device-to-host frame receiver with a configurable clock-glitch filter. It checks the start bit, odd parity and the stop bit, and has an optional watchdog that aborts stalled frames. It sits between the raw `ps2c`/`ps2d` pins and the keyboard/mouse decode logic, and flags frame errors so downstream logic can discard bad bytes.

## Interface
- `FILTER_LEN`, default 8: depth of the `ps2c` glitch filter in clk cycles; legal range 2..32.
- `TIMEOUT_CYCLES`, default 50000: inter-edge watchdog limit in clk cycles (1 ms at 50 MHz); must be ≥2. The counter width is $clog2(TIMEOUT_CYCLES).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2d`  in  1  raw PS/2 data line.
- `ps2c`  in  1  raw PS/2 clock line.
- `rx_en`  in  1  permits acceptance of a new start bit.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.
- `rx_done_tick`  out  1  one-cycle pulse; a frame has completed.
- `dout`  out  8  received data byte, LSB-first on the wire.
- `parity_err`  out  1  pulse coincident with `rx_done_tick`; odd parity failed.
- `frame_err`  out  1  pulse coincident with `rx_done_tick`; stop bit was 0.
- `timeout_tick`  out  1  one-cycle pulse; frame aborted by the watchdog.

## Operation
- Glitch filter:
  - `filt_reg[FILTER_LEN-1:0]` shifts `ps2c` in at the MSB each clock.
  - `f_ps2c` is set to 1 when `filt_reg` is all ones and cleared to 0 when it is all zeros; otherwise it holds its value.
  - `fall_edge` = `f_ps2c_reg & ~f_ps2c_next`. It is combinational and asserts for one cycle.
- Frame format: start(0), d0..d7, odd parity, stop(1). That is 11 bits, shifted right into `b_reg[10:0]`, sampled from raw `ps2d` on `fall_edge`.
- FSM states: IDLE, DPS, LOAD.
  - **IDLE**:
    - On `fall_edge & rx_en & ~ps2d`: shift in the start bit, load `n` with 9, clear the watchdog, and go to DPS.
    - On `fall_edge` with `ps2d=1` or `rx_en=0`: ignore the edge and stay in IDLE.
  - **DPS**:
    - On each `fall_edge`: shift in `ps2d`.
    - If `n==0`, go to LOAD; otherwise decrement `n`.
    - This gives 10 shifts in DPS, for 11 bits in total.
  - **LOAD**:
    - Assert `rx_done_tick` for exactly one cycle.
    - `parity_err` = `~^b_reg[9:1]` and `frame_err` = `~b_reg[10]`, both gated by `rx_done_tick`.
    - Next state is IDLE.
- `dout` = `b_reg[8:1]` continuously. It is guaranteed correct in the `rx_done_tick` cycle and holds until the next accepted start bit.
- `rx_en` gates only the start bit. Deasserting `rx_en` mid-frame does not abort the frame.
- Watchdog (see Configuration):
  - In DPS, the counter increments every cycle and is cleared on `fall_edge`.
  - When the count reaches TIMEOUT_CYCLES-1 and there is no `fall_edge` in that cycle, the FSM goes to IDLE and pulses `timeout_tick`. No `rx_done_tick` is issued for that frame.
  - If `fall_edge` and expiry occur in the same cycle, `fall_edge` wins and the frame continues.

## Timing
- Reset values:
  - FSM in IDLE.
  - `filt_reg`=0, `f_ps2c_reg`=0, `b_reg`=0, `n`=0, watchdog=0.
  - All outputs 0: `dout`=0x00, `rx_busy`=0, and all ticks and error flags 0.
- Reset mid-frame discards the partial frame; no tick is generated.
- `fall_edge` fires FILTER_LEN clock edges after `ps2c` has settled low, provided `f_ps2c` was 1.
- The `rx_done_tick` cycle is the cycle after the `fall_edge` that samples the stop bit.
- `rx_busy` rises the cycle after the start edge and falls the cycle after LOAD or after the timeout.
- `timeout_tick` occurs exactly TIMEOUT_CYCLES cycles after the last `fall_edge` accepted in DPS.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined: the watchdog counter and the abort path are compiled in.
- `PS2_RX_TIMEOUT_EN` undefined:
  - No counter is built.
  - `timeout_tick` is tied to 0.
  - DPS waits indefinitely for edges; only `reset` recovers a stalled frame.
  - `TIMEOUT_CYCLES` is accepted but unused.

## Test plan
Bench parameters: FILTER_LEN=4, TIMEOUT_CYCLES=1000, `PS2_RX_TIMEOUT_EN` defined, PS/2 bit period 200 clk.

1. **Good frame.** `rx_en`=1; send byte 0x1C with parity 0 and stop 1. Expect one `rx_done_tick`, `dout`=0x1C, `parity_err`=0, `frame_err`=0, and `rx_busy` low afterwards.
2. **Parity error.** Send 0x1C with parity 1. Expect `rx_done_tick` with `dout`=0x1C and `parity_err`=1 in the same cycle, `frame_err`=0.
3. **Stop-bit error.** Send 0xF0 with parity 1 and stop 0. Expect `rx_done_tick` with `dout`=0xF0, `frame_err`=1, `parity_err`=0.
4. **Start-bit rejection.** Drive one `ps2c` falling edge with `ps2d`=1, and also a valid start edge while `rx_en`=0. Expect `rx_busy` to stay 0 and no ticks.
5. **Timeout and recovery.** Send a start bit plus 4 data bits, then hold `ps2c` high. Expect `timeout_tick` exactly 1000 cycles after the 5th edge, no `rx_done_tick`, and `rx_busy`=0. A following 0xAA frame with parity 1 is then received with no errors.
6. **Reset and glitch immunity.** Assert `reset` after 6 bits of a frame, then release. Expect all outputs to be 0 and no tick. Next, inject 2-cycle low glitches on `ps2c` while it is idle high. Expect no `fall_edge` and `rx_busy`=0.
